// File: rtl/segway_pkg.sv
// Shared constants, saturation helpers and calibration state type
// for the segway inertial front end.
package segway_pkg;

    localparam int ACC_SCALE   = 327;
    localparam int FUSION_STEP = 1024;
    localparam int PTCH_INT_W  = 27;

    typedef enum logic {
        CAL = 1'b0,
        RUN = 1'b1
    } cal_state_t;

    function automatic logic signed [15:0] sat16(
        input logic signed [16:0] v
    );
        if (v[16] != v[15])
            return v[16] ? 16'sh8000 : 16'sh7FFF;
        return v[15:0];
    endfunction

    function automatic logic signed [PTCH_INT_W-1:0] sat27(
        input logic signed [PTCH_INT_W:0] v
    );
        if (v[PTCH_INT_W] != v[PTCH_INT_W-1])
            return v[PTCH_INT_W] ? {1'b1, {(PTCH_INT_W-1){1'b0}}}
                                 : {1'b0, {(PTCH_INT_W-1){1'b1}}};
        return v[PTCH_INT_W-1:0];
    endfunction

endpackage

// File: rtl/inert_gyro_cal.sv
// Power-up gyro calibration: averages 2^CAL_LOG2 raw rate samples
// into the rate offset, then stays in RUN until reset.
module inert_gyro_cal
    import segway_pkg::*;
#(
    parameter int CAL_LOG2 = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vld_in,
    input  logic signed [15:0] ptch_rt_raw,
    output logic signed [15:0] offset,
    output logic               cal_done
);

    localparam int SW = 16 + CAL_LOG2;

    cal_state_t          state;
    cal_state_t          state_nxt;
    logic [SW-1:0]       sum;
    logic [SW-1:0]       sum_nxt;
    logic [CAL_LOG2-1:0] cnt;
    logic                take;
    logic                last;

    assign take    = (state == CAL) && vld_in;
    assign last    = take && (&cnt);
    assign sum_nxt = sum + {{CAL_LOG2{ptch_rt_raw[15]}}, ptch_rt_raw};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= CAL;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            CAL:     if (last) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = CAL;
        endcase
    end

    always_comb begin
        cal_done = (state == RUN);
    end

    // Offset is the arithmetic-shifted sum including the final sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum    <= '0;
            cnt    <= '0;
            offset <= '0;
        end else begin
            if (take) begin
                sum <= sum_nxt;
                cnt <= cnt + 1'b1;
            end
            if (last) offset <= sum_nxt[CAL_LOG2 +: 16];
        end
    end

endmodule

// File: rtl/inert_integrator.sv
// Pitch integrator with complementary-filter drift correction.
// Optional gyro calibration: define INERT_GYRO_CAL_EN.
module inert_integrator
    import segway_pkg::*;
#(
    parameter logic [15:0] PTCH_RT_OFFSET = 16'h0050,
    parameter logic [15:0] AZ_OFFSET      = 16'hFE80,
    parameter int          CAL_LOG2       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vld_in,
    input  logic signed [15:0] ptch_rt_raw,
    input  logic signed [15:0] AZ,
    output logic signed [15:0] ptch,
    output logic signed [15:0] ptch_rt,
    output logic               vld,
    output logic               cal_done
);

    if (CAL_LOG2 < 2 || CAL_LOG2 > 8) begin : g_bad_cal_log2
        $error("CAL_LOG2 out of range 2..8");
    end

    logic signed [15:0] offset;

`ifdef INERT_GYRO_CAL_EN
    inert_gyro_cal #(
        .CAL_LOG2 (CAL_LOG2)
    ) u_cal (
        .clk         (clk),
        .rst_n       (rst_n),
        .vld_in      (vld_in),
        .ptch_rt_raw (ptch_rt_raw),
        .offset      (offset),
        .cal_done    (cal_done)
    );
`else
    assign offset   = PTCH_RT_OFFSET;
    assign cal_done = 1'b1;
`endif

    logic                         accept;
    logic                         v1;
    logic                         v2;
    logic signed [15:0]           rt1;
    logic signed [15:0]           az1;
    logic signed [15:0]           rt2;
    logic signed [15:0]           acc2;
    logic signed [16:0]           rt_diff;
    logic signed [25:0]           prod;
    logic signed [PTCH_INT_W-1:0] ptch_int;
    logic signed [PTCH_INT_W-1:0] fusion;
    logic signed [PTCH_INT_W:0]   int_sum;

    // Calibration samples never enter the pipeline
    assign accept  = vld_in & cal_done;
    assign rt_diff = {ptch_rt_raw[15], ptch_rt_raw}
                   - {offset[15], offset};
    assign prod    = $signed({{10{az1[15]}}, az1})
                   * $signed(26'(ACC_SCALE));
    assign ptch    = ptch_int[PTCH_INT_W-1 -: 16];

    always_comb begin
        fusion = '0;
        unique case (1'b1)
            (acc2 > ptch): fusion = PTCH_INT_W'(FUSION_STEP);
            (acc2 < ptch): fusion = PTCH_INT_W'(-FUSION_STEP);
            default:       fusion = '0;
        endcase
    end

    assign int_sum = {ptch_int[PTCH_INT_W-1], ptch_int}
                   - {{(PTCH_INT_W-15){rt2[15]}}, rt2}
                   + {fusion[PTCH_INT_W-1], fusion};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            vld      <= 1'b0;
            rt1      <= '0;
            az1      <= '0;
            rt2      <= '0;
            acc2     <= '0;
            ptch_int <= '0;
            ptch_rt  <= '0;
        end else begin
            v1  <= accept;
            v2  <= v1;
            vld <= v2;
            if (accept) begin
                rt1 <= sat16(rt_diff);
                az1 <= AZ - AZ_OFFSET;
            end
            if (v1) begin
                rt2  <= rt1;
                acc2 <= 16'(prod >>> 13);
            end
            if (v2) begin
                ptch_int <= sat27(int_sum);
                ptch_rt  <= rt2;
            end
        end
    end

endmodule

// File: tb/tb_inert_integrator.sv
// Bench for inert_integrator: directed steps plus random traffic,
// checked against an arithmetic model of the pitch filter.
module tb_inert_integrator;

    localparam int L     = 4;
    localparam int OFF   = 'h50;
    localparam int AZOFF = -384;
    localparam int LIM   = 1 << 26;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               vld_in = 1'b0;
    logic signed [15:0] raw = '0;
    logic signed [15:0] az = '0;
    logic signed [15:0] ptch, ptch_rt, ptch_b, ptch_rt_b;
    logic               vld, cal_done, vld_b, cal_done_b;

    always #5 clk = ~clk;

    inert_integrator u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vld_in      (vld_in),
        .ptch_rt_raw (raw),
        .AZ          (az),
        .ptch        (ptch),
        .ptch_rt     (ptch_rt),
        .vld         (vld),
        .cal_done    (cal_done)
    );

    inert_integrator #(
        .PTCH_RT_OFFSET (16'hFF00)
    ) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .vld_in      (vld_in),
        .ptch_rt_raw (raw),
        .AZ          (az),
        .ptch        (ptch_b),
        .ptch_rt     (ptch_rt_b),
        .vld         (vld_b),
        .cal_done    (cal_done_b)
    );

    typedef struct {
        int due;
        int rt;
        int acc;
    } job_t;

    job_t q[$];
    int   total = 0;
    int   bad = 0;
    int   ec = 0;
    int   m_int, m_ptch, m_rt, m_off, m_cnt, m_sum;
    int   m_cal;

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic chk(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_int  = 0;
        m_ptch = 0;
        m_rt   = 0;
        m_cnt  = 0;
        m_sum  = 0;
        q.delete();
`ifdef INERT_GYRO_CAL_EN
        m_cal = 0;
        m_off = 0;
`else
        m_cal = 1;
        m_off = OFF;
`endif
    endtask

    task automatic cyc(input bit v, input int r, input int a);
        int rs, azc, fus, ev;
        logic signed [15:0] t;
        job_t j;
        vld_in = v;
        raw    = 16'(r);
        az     = 16'(a);
        rs     = int'(raw);
        t      = az - 16'(AZOFF);
        azc    = int'(t);
        @(posedge clk);
        ec++;
        if (v) begin
            if (m_cal != 0) begin
                j.due = ec + 2;
                j.rt  = clamp(rs - m_off, -32768, 32767);
                j.acc = (azc * 327) >>> 13;
                q.push_back(j);
            end else begin
                m_sum += rs;
                m_cnt++;
                if (m_cnt == (1 << L)) begin
                    m_cal = 1;
                    m_off = m_sum >>> L;
                end
            end
        end
        #1;
        ev = 0;
        if (q.size() > 0 && q[0].due == ec) begin
            j = q.pop_front();
            fus = (j.acc > m_ptch) ? 1024 :
                  (j.acc < m_ptch) ? -1024 : 0;
            m_int  = clamp(m_int - j.rt + fus, -LIM, LIM - 1);
            m_ptch = m_int >>> 11;
            m_rt   = j.rt;
            ev     = 1;
        end
        chk("vld", vld, ev);
        chk("ptch", ptch, m_ptch);
        chk("ptch_rt", ptch_rt, m_rt);
        chk("cal_done", cal_done, m_cal);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 'hFE80);
    endtask

    task automatic do_reset();
        model_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_ptch", ptch, 0);
        chk("rst_ptch_rt", ptch_rt, 0);
        chk("rst_vld", vld, 0);
        chk("rst_cal_done", cal_done, m_cal);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic calibrate(input int r);
`ifdef INERT_GYRO_CAL_EN
        for (int i = 0; i < (1 << L); i++) begin
            chk("cal_low", cal_done, 0);
            cyc(1'b1, r, 'hFE80);
        end
        chk("cal_rise", cal_done, 1);
`else
        cyc(1'b0, r, 'hFE80);
`endif
    endtask

    initial begin
        int p, prev;
        #1;
        do_reset();

`ifdef INERT_GYRO_CAL_EN
        calibrate('h60);
        cyc(1'b1, 'h60, 'hFE80);
        idle(2);
        chk("cal_vld17", vld, 1);
        chk("cal_rt17", ptch_rt, 0);
        do_reset();
`endif

        calibrate('h50);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 'h50, 'hFE80);
            idle(i % 3);
        end
        idle(3);
        chk("zero_ptch", ptch, 0);
        chk("zero_rt", ptch_rt, 0);

        do_reset();
        calibrate('h50);
        cyc(1'b1, 'h850, 'hFE80);
        idle(2);
        chk("one_ptch", ptch, 16'shFFFF);
        chk("one_rt", ptch_rt, 'h800);
        cyc(1'b1, 'h850, 'hFE80);
        idle(2);
        chk("two_ptch", ptch, 16'shFFFE);

        do_reset();
        calibrate('h50);
        prev = 0;
        for (int i = 0; i < 400; i++) begin
            cyc(1'b1, 'h50, 'h0E80);
            p = int'(ptch);
            chk("mono", int'(p >= prev), 1);
            prev = p;
        end
        idle(3);
        p = int'(ptch);
        chk("conv", int'(p >= 162 && p <= 163), 1);

        cyc(1'b1, 'h8000, 'hFE80);
        cyc(1'b1, 'h7FFF, 'hFE80);
        idle(1);
        chk("sat_rt_lo", ptch_rt, 16'sh8000);
`ifndef INERT_GYRO_CAL_EN
        idle(1);
        chk("sat_rt_hi", ptch_rt_b, 16'sh7FFF);
`endif

        for (int i = 0; i < 2300; i++) cyc(1'b1, 'h8000, 'hFE80);
        idle(3);
        chk("sat_int_hi", ptch, 16'sh7FFF);
        for (int i = 0; i < 4400; i++) cyc(1'b1, 'h7FFF, 'hFE80);
        idle(3);
        chk("sat_int_lo", ptch, 16'sh8000);

        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 1)),
                int'($urandom_range(0, 65535)),
                int'($urandom_range(0, 65535)));
        idle(3);

        do_reset();
        calibrate('h50);
        for (int i = 0; i < 20; i++)
            cyc(1'b1, int'($urandom_range(0, 255)), 'h0E80);
        do_reset();
        for (int i = 0; i < 15; i++) cyc(1'b1, 'h50, 'hFE80);
`ifdef INERT_GYRO_CAL_EN
        chk("recal_low", cal_done, 0);
        cyc(1'b1, 'h50, 'hFE80);
        chk("recal_rise", cal_done, 1);
`endif
        for (int i = 0; i < 30; i++)
            cyc(1'($urandom_range(0, 1)),
                int'($urandom_range(0, 65535)),
                int'($urandom_range(0, 65535)));
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inert_integrator.md
# inert_integrator

Upstream neighbour of the balance PID. Converts raw inertial readings (pitch-rate gyro, vertical accel) into the signed 16-bit `ptch`, `ptch_rt` and `vld` that the PID consumes. It integrates the offset-compensated pitch rate and corrects drift with a complementary-filter fusion term derived from the accelerometer. An optional power-up gyro calibration replaces the fixed rate offset with a measured one.

## Interface
Parameters:
- `PTCH_RT_OFFSET`, 16'h0050: fixed gyro offset, used when calibration is compiled out.
- `AZ_OFFSET`, 16'hFE80: accelerometer zero offset.
- `CAL_LOG2`, 4: log2 of the number of calibration samples (range 2..8).

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `vld_in`, in, 1: single-cycle strobe; the raw inputs are valid this cycle.
- `ptch_rt_raw`, in, 16 signed: raw pitch-rate reading.
- `AZ`, in, 16 signed: raw vertical acceleration.
- `ptch`, out, 16 signed: fused pitch, `ptch_int[26:11]`.
- `ptch_rt`, out, 16 signed, registered: offset-compensated pitch rate.
- `vld`, out, 1: one-cycle pulse when `ptch` and `ptch_rt` update.
- `cal_done`, out, 1: offset is valid and the block is integrating.

## Operation
Datapath:
- `rt_comp = sat16(ptch_rt_raw - offset)`. The subtraction is done 17-bit, then saturated to 16'h7FFF or 16'h8000.
- `az_comp = AZ - AZ_OFFSET`, 16-bit, wraps.
- `ptch_acc`: compute `prod = az_comp * 327` (signed, 26 bits). `ptch_acc = prod >>> 13`, truncated to 16 bits (arithmetic shift).
- `ptch_int`: 27-bit signed accumulator. Per valid sample: `ptch_int <= sat27(ptch_int - sext(rt_comp) + fusion)`.
  - `fusion` = +1024 if `ptch_acc > ptch`.
  - `fusion` = -1024 if `ptch_acc < ptch`.
  - `fusion` = 0 if they are equal.
  - `ptch` is the current registered value.
  - On overflow, saturate to +/-2^26 limits. Wrap is forbidden.

State machine (only with calibration compiled in):
- `CAL`, entered from reset:
  - Each `vld_in` adds `sext(ptch_rt_raw)` to a (16+`CAL_LOG2`)-bit sum and increments a sample counter.
  - Samples do not enter the pipeline and `vld` stays 0.
  - On the 2^`CAL_LOG2`-th sample, `offset <= sum >>> CAL_LOG2` next cycle, state moves to `RUN`, and `cal_done` rises.
- `RUN`, terminal: every `vld_in` enters the pipeline.

Boundary conditions:
- Back-to-back `vld_in` on every cycle is legal; the pipeline accepts one sample per cycle.
  - The fusion compare uses `ptch` as registered at the accumulate cycle.
- A `vld_in` on the same cycle that calibration completes is the last calibration sample, never a run sample.
- Reset mid-operation clears all state and restarts calibration.

## Timing
- Reset values: `ptch` = 0, `ptch_rt` = 0, `vld` = 0, `cal_done` = 0 (calibration in) or 1 (calibration out), `ptch_int` = 0, `offset` = 0 or `PTCH_RT_OFFSET`.
- Run pipeline, with `vld_in` at cycle N:
  - N+1: `rt_comp` and `az_comp` registered.
  - N+2: `ptch_acc` registered; `rt_comp` delayed.
  - N+3: `ptch_int` and `ptch_rt` updated, `vld` = 1 for exactly one cycle.
- Latency is 3 cycles. Throughput is 1 sample per cycle.
- Calibration: `cal_done` rises at M+1, where M is the cycle of the final calibration `vld_in`.

## Configuration
- `INERT_GYRO_CAL_EN` defined:
  - `CAL`/`RUN` FSM, sum register and counter are present.
  - Offset is measured.
  - `PTCH_RT_OFFSET` is unused.
- Not defined:
  - No FSM.
  - Offset is the constant `PTCH_RT_OFFSET`.
  - `cal_done` is tied to 1.
  - The first `vld_in` after reset is processed.

## Structure
- Package `segway_pkg` holds:
  - the `ACC_SCALE` = 327 constant;
  - the `FUSION_STEP` = 1024 constant;
  - the `PTCH_INT_W` = 27 constant;
  - `sat16`/`sat27` functions;
  - the `cal_state_t` enum.
- One sub-module, `inert_gyro_cal`: the FSM, accumulator and offset register, instantiated only under `INERT_GYRO_CAL_EN`.

## Test plan
- Macro off; `ptch_rt_raw` = 16'h0050, `AZ` = 16'hFE80; 10 strobes -> `ptch_rt` = 0, `ptch` = 0 throughout; each `vld` pulse exactly 3 cycles after its `vld_in`.
- Macro off; `ptch_rt_raw` = 16'h0850, `AZ` = 16'hFE80, one strobe -> `ptch_int` = -2048, `ptch` = 16'hFFFF; second strobe -> `ptch_int` = -2048 - 2048 + 1024 = -3072.
- Macro off; `AZ` = 16'h0E80 (so `az_comp` = 4096, `ptch_acc` = 163), rate at offset -> `ptch` increases monotonically; after 400 strobes `ptch` is within 162..163.
- Macro off; `ptch_rt_raw` = 16'h8000 -> `ptch_rt` = 16'h8000 (saturated, no wrap); `ptch_rt_raw` = 16'h7FFF with offset 16'hFF00 -> `ptch_rt` = 16'h7FFF.
- Macro on, `CAL_LOG2` = 4:
  - 16 strobes with raw 16'h0060 -> no `vld`, and `cal_done` rises 1 cycle after the 16th strobe.
  - 17th strobe with raw 16'h0060 -> `ptch_rt` = 0 at +3.
- Macro on, `rst_n` pulsed low mid-run after 20 strobes -> `ptch`, `ptch_rt`, `vld`, `cal_done` read 0 immediately (asynchronous); calibration restarts and requires 16 new strobes.
